// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter (per-owner hold quantum) in front of a single-port on-chip RAM.
// Define ONCHIP_MEM_ARB_FIXED_PRIO_EN to replace round-robin with strict master-0 priority.
module onchip_mem_arbiter #(
  parameter int  ADDR_W  = 12,
  parameter int  DATA_W  = 32,
  parameter int  QUANTUM = 4,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] QUANT = 4'(QUANTUM);

  state_t     state;
  logic       last_owner;
  logic [3:0] count;
  logic       rd_pending;
  logic       rd_owner;

  logic       req0, req1;
  logic       grant0, grant1;
  logic [3:0] count_inc;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign count_inc = (count >= QUANT) ? count : count + 4'd1;

  // Grant is decided in the same cycle from registered state and live requests.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
      grant0 = req0;
      grant1 = req1 & ~req0;
`else
      if (state == OWN0 && req0) begin
        if (req1 && count >= QUANT) grant1 = 1'b1;
        else                        grant0 = 1'b1;
      end else if (state == OWN1 && req1) begin
        if (req0 && count >= QUANT) grant0 = 1'b1;
        else                        grant1 = 1'b1;
      end else if (req0 && req1) begin
        // An owner that dropped its request is treated as idle; last_owner already names it.
        grant0 = last_owner;
        grant1 = ~last_owner;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      count      <= 4'd0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      // A read asserted together with a write is performed as a write only.
      rd_pending <= (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
      if (grant0 | grant1)
        rd_owner <= grant1;

      if (grant0) begin
        state      <= OWN0;
        last_owner <= 1'b0;
        count      <= (state == OWN0) ? count_inc : 4'd1;
      end else if (grant1) begin
        state      <= OWN1;
        last_owner <= 1'b1;
        count      <= (state == OWN1) ? count_inc : 4'd1;
      end else begin
        state <= IDLE;
        count <= 4'd0;
      end
    end
  end

  assign m0_waitrequest   = reset | (req0 & ~grant0);
  assign m1_waitrequest   = reset | (req1 & ~grant1);

  assign m0_readdatavalid = rd_pending & ~rd_owner;
  assign m1_readdatavalid = rd_pending &  rd_owner;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

  assign mem_address      = grant1 ? m1_address    : m0_address;
  assign mem_byteenable   = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata    = grant1 ? m1_writedata  : m0_writedata;
  assign mem_write        = (grant0 & m0_write) | (grant1 & m1_write);
  assign mem_chipselect   = grant0 | grant1;
  assign mem_clken        = ~reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus randomized traffic
// checked against a streak-based arbitration model and a reference memory image.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int Q      = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram     [0:4095];
  logic [DATA_W-1:0] ref_mem [0:4095];

  // Reference model: which master got the previous cycle, how long its unbroken run is,
  // and who was granted most recently; pending read results expected next cycle.
  int                prev_grant;
  int                streak;
  int                last_g;
  bit                pend_v [2];
  logic [DATA_W-1:0] pend_d [2];

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUANTUM(Q)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // Registered-input single-port RAM: read data appears the cycle after issue.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] d,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Returns the master expected to be granted (-1 for none).
  function automatic int predict(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1)   return r0 ? 0 : 1;
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
    return 0;
`else
    if (prev_grant < 0) return 1 - last_g;
    return (streak < Q) ? prev_grant : 1 - prev_grant;
`endif
  endfunction

  task automatic model_reset();
    prev_grant = -1;
    streak     = 0;
    last_g     = 1;
    pend_v     = '{1'b0, 1'b0};
  endtask

  task automatic accept(input int n, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    check("mem_address", mem_address, a);
    check("mem_write", mem_write, wr);
    if (wr) begin
      check("mem_writedata", mem_writedata, d);
      check("mem_byteenable", mem_byteenable, be);
      ref_mem[a] = merge(ref_mem[a], d, be);
    end else if (rd) begin
      pend_v[n] = 1'b1;
      pend_d[n] = ref_mem[a];
    end
  endtask

  // Evaluates one cycle shortly after the falling edge: compares outputs, then advances the model.
  task automatic eval_cycle();
    bit r0, r1;
    int g;
    #1;
    if (reset) begin
      check("rst_wait0", m0_waitrequest, 1);
      check("rst_wait1", m1_waitrequest, 1);
      check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
      check("rst_rdata", {m0_readdata, m1_readdata}, 0);
      check("rst_mem", {mem_chipselect, mem_write, mem_clken}, 0);
      model_reset();
      return;
    end
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g  = predict(r0, r1);
    check("wait0", m0_waitrequest, r0 && g != 0);
    check("wait1", m1_waitrequest, r1 && g != 1);
    check("rdv0", m0_readdatavalid, pend_v[0]);
    check("rdv1", m1_readdatavalid, pend_v[1]);
    check("rdata0", m0_readdata, pend_v[0] ? pend_d[0] : 32'h0);
    check("rdata1", m1_readdata, pend_v[1] ? pend_d[1] : 32'h0);
    check("chipselect", mem_chipselect, g >= 0);
    check("clken", mem_clken, 1);
    pend_v = '{1'b0, 1'b0};
    if (g == 0)
      accept(0, m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
    else if (g == 1)
      accept(1, m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
    if (g < 0) begin
      prev_grant = -1;
      streak     = 0;
    end else begin
      streak     = (g == prev_grant) ? streak + 1 : 1;
      prev_grant = g;
      last_g     = g;
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic cycle();
    eval_cycle();
    next_cycle();
  endtask

  task automatic drive(input int n, input bit r, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    if (n == 0) begin
      m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    idle_all();
    cycle();
    reset = 1'b0;
  endtask

  task automatic drive_random(input int n);
    int k;
    k = $urandom_range(0, 9);
    drive(n, (k < 4) || (k == 7), (k >= 4) && (k <= 7),
          ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    model_reset();
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;

    // Write then read back the same word from master 0.
    drive(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
    eval_cycle(); check("t1_wr_wait", m0_waitrequest, 0); next_cycle();
    drive(0, 1, 0, 12'h010, 4'hF, 32'h0);
    eval_cycle(); check("t1_rd_wait", m0_waitrequest, 0); next_cycle();
    idle_all();
    eval_cycle();
    check("t1_rdv", m0_readdatavalid, 1);
    check("t1_rdata", m0_readdata, 32'hDEADBEEF);
    next_cycle();

`ifndef ONCHIP_MEM_ARB_FIXED_PRIO_EN
    // Continuous reads from both masters: m0 x4, m1 x4, m0 x4.
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 12'($urandom), 4'hF, 32'h0);
      drive(1, 1, 0, 12'($urandom), 4'hF, 32'h0);
      eval_cycle();
      check("t2_grant", {m0_waitrequest, m1_waitrequest}, ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0)
        check("t2_rdv", {m0_readdatavalid, m1_readdatavalid},
              (((i - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01);
      next_cycle();
    end
    idle_all();
    eval_cycle();
    check("t2_rdv_last", {m0_readdatavalid, m1_readdatavalid}, 2'b10);
    next_cycle();
`else
    // Strict priority: master 0 holds the RAM while both request.
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 12'($urandom), 4'hF, 32'h0);
      drive(1, 1, 0, 12'($urandom), 4'hF, 32'h0);
      eval_cycle();
      check("fp_wait0", m0_waitrequest, 0);
      check("fp_wait1", m1_waitrequest, 1);
      next_cycle();
    end
    idle_all();
    cycle();
`endif

    // Partial byteenable write over an all-ones word.
    drive(0, 0, 1, 12'h7FF, 4'hF, 32'hFFFFFFFF); cycle();
    drive(0, 0, 1, 12'h7FF, 4'h3, 32'h12345678); cycle();
    drive(0, 1, 0, 12'h7FF, 4'hF, 32'h0);        cycle();
    idle_all();
    eval_cycle();
    check("t3_rdata", m0_readdata, 32'hFFFF5678);
    next_cycle();

    // Same-cycle contention after master 1 was the last owner.
    drive(0, 0, 1, 12'hFFF, 4'hF, 32'h11111111); cycle();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 1, 0, 12'h020, 4'hF, 32'h0);        cycle();
    idle_all();                                   cycle();
    drive(1, 0, 1, 12'hFFF, 4'hF, 32'h22222222);
    drive(0, 1, 0, 12'hFFF, 4'hF, 32'h0);
    eval_cycle();
    check("t4_first", {m0_waitrequest, m1_waitrequest}, 2'b01);
    next_cycle();
    drive(0, 0, 0, '0, '0, '0);
    eval_cycle();
    check("t4_m1_acc", m1_waitrequest, 0);
    check("t4_old", m0_readdata, 32'h11111111);
    next_cycle();
    drive(1, 0, 0, '0, '0, '0);
    drive(0, 1, 0, 12'hFFF, 4'hF, 32'h0);        cycle();
    idle_all();
    eval_cycle();
    check("t4_new", m0_readdata, 32'h22222222);
    next_cycle();

    // Reset right after an accepted master-1 read discards the pending data.
    drive(1, 1, 0, 12'h030, 4'hF, 32'h0);
    eval_cycle();
    check("t5_acc", m1_waitrequest, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_cs", mem_chipselect, 0);
    check("t5_wait1", m1_waitrequest, 1);
    model_reset();
    next_cycle();
    eval_cycle();
    check("t5_rdv", m1_readdatavalid, 0);
    next_cycle();
    reset = 1'b0;
    idle_all();
    cycle();

    // Randomized traffic with a reset pulse in the middle.
    for (int i = 0; i < 300; i++) begin
      reset = (i == 150);
      drive_random(0);
      drive_random(1);
      cycle();
    end
    reset = 1'b0;
    idle_all();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master arbiter that shares the single-port 4096×32 on-chip RAM between two Avalon-MM style requesters: the CPU data path (master 0) and the audio/feature DMA (master 1). It issues at most one transfer per clock to the RAM and grants round-robin with a per-owner hold quantum. It returns read data with a fixed one-cycle latency, tagged back to the issuing master. It sits between the two masters and the RAM's address/byteenable/chipselect/write/writedata/clken/readdata pins.

## Interface
- ADDR_W, 12, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
- QUANTUM, 4, max consecutive transfers granted to one master while the other is requesting (1..15)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDR_W  master N word address (N = 0, 1)
- mN_byteenable  in  BE_W  master N byte lanes
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_W  master N write data
- mN_waitrequest  out  1  master N request not accepted this cycle
- mN_readdata  out  DATA_W  read data to master N
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM readdata (valid cycle after issue)

## Operation
- reqN = mN_read | mN_write. mN_read & mN_write together is illegal; the write is performed and no readdatavalid is returned.
- FSM states: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit), hold count (4 bits), rd_pending, rd_owner.
- IDLE: if exactly one reqN is high, grant N. If both are high, grant the master != last_owner. If none, stay.
- OWNn with reqn high and other request low: keep grant; count saturates at QUANTUM.
- OWNn with reqn high, other request high, count < QUANTUM: keep grant, count += 1.
- OWNn with count == QUANTUM and other request high: grant the other master; count reset to 1.
- OWNn with reqn low: behave as IDLE with last_owner = n.
- Grant is decided combinationally in the same cycle from the registered state and the current requests. The granted master's signals are muxed onto mem_*. mem_chipselect = granted req; mem_write = granted write.
- mN_waitrequest = reqN & ~grantN. The granted transfer is accepted in the same cycle.
- On an accepted read: rd_pending <= 1, rd_owner <= N. Next cycle: mN_readdata = mem_readdata and mN_readdatavalid = 1 for the owner only.
- The non-owner's readdata = 0.
- mem_clken = ~reset.
- Address wrap: none. Addresses pass through unmodified.

## Timing
- Reset values:
  - state IDLE, last_owner 1 (master 0 wins first contention), count 0, rd_pending 0.
  - mN_waitrequest 1 while reset is high, mN_readdatavalid 0, mN_readdata 0.
  - mem_chipselect 0, mem_write 0, mem_clken 0.
- Acceptance latency 0 cycles when granted. Read latency exactly 1 cycle after acceptance.
- Throughput is one transfer per cycle, back-to-back reads pipelined.
- Grant switch costs no idle cycle.
- Write then read to the same address in consecutive cycles returns the new data (RAM is registered-input).
- Reset asserted mid-transfer: pending read data is discarded, with no readdatavalid after reset. The FSM returns to IDLE asynchronously.

## Configuration
- ONCHIP_MEM_ARB_FIXED_PRIO_EN defined: master 0 always wins contention, QUANTUM and last_owner are ignored, and master 1 is served only when master 0 is idle.
- Macro not defined: round-robin with QUANTUM hold as described above.

## Test plan
- Reset released, m0 writes 0xDEADBEEF @0x010 with byteenable 0xF, then reads @0x010 -> m0_waitrequest 0 both cycles; m0_readdatavalid 1 one cycle after the read with 0xDEADBEEF.
- Both masters read continuously from cycle 0, QUANTUM = 4 -> grants m0 ×4, m1 ×4, m0 ×4. Each readdatavalid goes only to the issuing master, one cycle after its acceptance.
- Byteenable 0x3 write of 0x12345678 over 0xFFFFFFFF @0x7FF -> readback 0xFFFF5678.
- m1 write @0xFFF and m0 read @0xFFF in the same cycle, after both were idle with last_owner 1 -> m0 is granted first and reads the old data; m1 is accepted the next cycle.
- Reset asserted the cycle after an accepted m1 read -> m1_readdatavalid stays 0 and mem_chipselect drops to 0 immediately.
- With ONCHIP_MEM_ARB_FIXED_PRIO_EN, both masters requesting for 10 cycles -> m0 is accepted all 10 cycles; m1_waitrequest stays 1 throughout.
